serial_add_sched: RTL and testbench
===================================

Name: serial_add_sched

Overview:
Scheduler wrapped around a bit-serial adder datapath, sharing one adder between two requesters. It arbitrates round-robin between requesters and captures the winner's operands. It sequences the add one bit per clock, LSB first, over WIDTH cycles. It returns sum, carry-out and winner id on a valid/ready result port. It sits between operand sources and the consumer of serial-add results.

Parameters:
WIDTH, 4, operand/sum width in bits (>=2); also number of SHIFT cycles per add.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req0_valid  input  1  requester 0 has operands
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_ready  output  1  requester 0 accepted this cycle when high with req0_valid
req1_valid  input  1  requester 1 has operands
req1_a  input  WIDTH  requester 1 operand a
req1_b  input  WIDTH  requester 1 operand b
req1_ready  output  1  requester 1 handshake
res_valid  output  1  result available
res_sum  output  WIDTH  (a+b) mod 2^WIDTH
res_cout  output  1  carry out of bit WIDTH-1
res_id  output  1  requester that produced result
res_ready  input  1  consumer accepts result
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, bit counter=0, carry=0, last_id=1 (req0 wins first contention). A reset mid-SHIFT/DONE aborts the op; no result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: grant is combinational. With one valid, grant goes to it. With both valid, grant goes to !last_id. reqN_ready = (state==IDLE) & grant==N & reqN_valid. At most one ready is high per cycle. Both ready are 0 in SHIFT/DONE.
- Accept edge (valid&ready): capture a,b into shift regs; carry=0, counter=0, res_id=N, last_id=N; go to SHIFT. Operands are sampled only on this edge; later input changes are ignored. Requesters must hold valid/data until ready.
- SHIFT, each edge: s = a[0]^b[0]^carry; carry = majority(a[0],b[0],carry); shift a,b right; shift sum reg right with s entering MSB; counter++. On the edge where counter==WIDTH-1, load res_sum, load res_cout=new carry, go to DONE. SHIFT lasts exactly WIDTH cycles.
- Latency: accept on edge T gives res_valid=1 after edge T+WIDTH.
- DONE: res_valid=1. res_sum/res_cout/res_id stay stable until res_ready. On an edge with res_valid&res_ready: res_valid=0, go to IDLE. No new accept in the same cycle. Minimum spacing between accepts is WIDTH+2 cycles when res_ready is held high.
- res_sum/res_cout/res_id hold their last values after the handshake until the next DONE load.
- busy is combinational from state.
- No X propagation: valid inputs are ignored outside IDLE.

Test Plan:
- WIDTH=4, req0 a=1,b=2, res_ready=1 -> req0_ready high in IDLE; res_valid high 4 cycles after accept; sum=0011, cout=0, id=0; IDLE next cycle.
- req1 a=15,b=1 -> sum=0000, cout=1, id=1; req0_ready stays 0 throughout.
- Both valid continuously, req0 a=3,b=2, req1 a=5,b=6 -> grants in order id0 (sum 0101), id1 (sum 1011, cout 0), id0; strict alternation.
- res_ready=0 for 5 cycles in DONE -> res_valid stays 1; sum/cout/id are stable; both req ready=0; busy=1. Raise res_ready -> IDLE next edge, then accept the pending request.
- After accepting req0 a=3,b=2, change req0_a to 15 during SHIFT -> result is still sum=0101.
- Assert rst=0 mid-SHIFT (between edges) -> res_valid=0, busy=0 immediately. After release with both valid, req0 is granted first.

Source files
------------

// File: rtl/serial_add_sched.sv
// ---------------------------------------------------------------------------
// serial_add_sched: round-robin scheduler sharing one LSB-first serial adder
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_add_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] res_sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             last_id_q;
  logic             res_valid_q;
  logic             res_cout_q;
  logic             res_id_q;

  logic             grant_w;
  logic             s_w;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;

  // With both requesters valid, the one not served last wins.
  always_comb begin
    grant_w = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_w = ~last_id_q;
    end else if (req1_valid) begin
      grant_w = 1'b1;
    end
  end

  assign req0_ready = (state_q == S_IDLE) && !grant_w && req0_valid;
  assign req1_ready = (state_q == S_IDLE) &&  grant_w && req1_valid;

  assign s_w     = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign sum_d   = {s_w, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      res_sum_q   <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      last_id_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_cout_q  <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_ready || req1_ready) begin
            a_q       <= req1_ready ? req1_a : req0_a;
            b_q       <= req1_ready ? req1_b : req0_b;
            res_id_q  <= req1_ready;
            last_id_q <= req1_ready;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            res_sum_q   <= sum_d;
            res_cout_q  <= carry_d;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sched.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sched: directed bench for serial_add_sched (WIDTH=4)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_sched;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;
  logic             res_ready;
  logic             busy;

  int total = 0;
  int bad   = 0;

  serial_add_sched #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until res_valid rises or the budget runs out; returns edges taken.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready = 1'b1;
    #2;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({res_sum, res_cout, res_id} !== 6'b0) begin bad++; $display("FAIL reset_result got=%b exp=000000", {res_sum, res_cout, res_id}); end
    tick(); tick();
    rst = 1'b1;
    tick();
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_idle_ready got=%b exp=00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single_req0();
    int cyc;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single0_ready got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    total++; if (busy !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL single0_shift got busy=%b valid=%b exp busy=1 valid=0", busy, res_valid); end
    wait_result(cyc);
    total++; if (cyc !== WIDTH) begin bad++; $display("FAIL single0_latency got=%0d exp=%0d", cyc, WIDTH); end
    total++; if ({res_sum, res_cout, res_id} !== {4'b0011, 1'b0, 1'b0}) begin bad++; $display("FAIL single0_result got sum=%b cout=%b id=%b exp sum=0011 cout=0 id=0", res_sum, res_cout, res_id); end
    tick();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single0_idle got valid=%b busy=%b exp 0 0", res_valid, busy); end
    total++; if (res_sum !== 4'b0011) begin bad++; $display("FAIL single0_hold got=%b exp=0011", res_sum); end
  endtask

  task automatic test_single_req1();
    int cyc;
    int r0_seen;
    r0_seen = 0;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL single1_ready got=%b exp=01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      if (req0_ready !== 1'b0) r0_seen++;
      tick();
      cyc++;
    end
    total++; if (cyc !== WIDTH) begin bad++; $display("FAIL single1_latency got=%0d exp=%0d", cyc, WIDTH); end
    total++; if (r0_seen !== 0) begin bad++; $display("FAIL single1_req0_ready got=%0d cycles high exp=0", r0_seen); end
    total++; if ({res_sum, res_cout, res_id} !== {4'b0000, 1'b1, 1'b1}) begin bad++; $display("FAIL single1_result got sum=%b cout=%b id=%b exp sum=0000 cout=1 id=1", res_sum, res_cout, res_id); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_sum [3];
    logic             exp_id  [3];
    int cyc;
    exp_sum[0] = 4'b0101; exp_id[0] = 1'b0;
    exp_sum[1] = 4'b1011; exp_id[1] = 1'b1;
    exp_sum[2] = 4'b0101; exp_id[2] = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd2;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if ({req0_ready, req1_ready} !== (exp_id[i] ? 2'b01 : 2'b10)) begin bad++; $display("FAIL b2b_grant%0d got=%b exp_id=%b", i, {req0_ready, req1_ready}, exp_id[i]); end
      tick();
      wait_result(cyc);
      total++; if (cyc !== WIDTH) begin bad++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", i, cyc, WIDTH); end
      total++; if ({res_sum, res_cout, res_id} !== {exp_sum[i], 1'b0, exp_id[i]}) begin bad++; $display("FAIL b2b_result%0d got sum=%b cout=%b id=%b exp sum=%b cout=0 id=%b", i, res_sum, res_cout, res_id, exp_sum[i], exp_id[i]); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    int unstable;
    unstable = 0;
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
    req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL bp_grant got=%b exp=01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    wait_result(cyc);
    total++; if (cyc !== WIDTH) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", cyc, WIDTH); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_valid !== 1'b1 || busy !== 1'b1 || {req0_ready, req1_ready} !== 2'b00 ||
          {res_sum, res_cout, res_id} !== {4'b0000, 1'b1, 1'b1}) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (sum=%b cout=%b id=%b)", unstable, res_sum, res_cout, res_id); end
    res_ready = 1'b1;
    tick();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%b busy=%b r0rdy=%b exp 0 0 1", res_valid, busy, req0_ready); end
    tick();
    req0_valid = 1'b0;
    wait_result(cyc);
    total++; if ({res_sum, res_cout, res_id} !== {4'b1000, 1'b0, 1'b0}) begin bad++; $display("FAIL bp_pending got sum=%b cout=%b id=%b exp sum=1000 cout=0 id=0", res_sum, res_cout, res_id); end
    tick();
  endtask

  task automatic test_operand_capture();
    int cyc;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd2;
    tick();
    req0_valid = 1'b0; req0_a = 4'd15;
    wait_result(cyc);
    total++; if ({res_sum, res_cout, res_id} !== {4'b0101, 1'b0, 1'b0}) begin bad++; $display("FAIL capture_result got sum=%b cout=%b id=%b exp sum=0101 cout=0 id=0", res_sum, res_cout, res_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL rstmid_pre_grant got=%b exp=01", {req0_ready, req1_ready}); end
    tick(); tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL rstmid_abort got busy=%b valid=%b exp 0 0", busy, res_valid); end
    total++; if (res_sum !== 4'b0000) begin bad++; $display("FAIL rstmid_sum got=%b exp=0000", res_sum); end
    tick();
    #5;
    rst = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rstmid_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(cyc);
    total++; if ({res_sum, res_cout, res_id} !== {4'b0010, 1'b0, 1'b0}) begin bad++; $display("FAIL rstmid_result got sum=%b cout=%b id=%b exp sum=0010 cout=0 id=0", res_sum, res_cout, res_id); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_single_req1();
    test_back_to_back();
    test_backpressure();
    test_operand_capture();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
